// File: rtl/hacd_pkg.sv
// Shared HACD types: AXI write packets, arbiter state encoding and sizing helpers.
package hacd_pkg;

  typedef struct packed {
    logic [63:0]  addr;
    logic [511:0] data;
    logic [63:0]  strb;
  } axi_wr_pld_t;

  typedef struct packed {
    logic         awvalid;
    logic         wvalid;
    logic [63:0]  addr;
    logic [511:0] data;
    logic [63:0]  strb;
  } axi_wr_reqpkt_t;

  typedef struct packed {
    logic awready;
    logic wready;
  } axi_wr_rdypkt_t;

  typedef struct packed {
    logic bresp;
    logic bvalid;
  } axi_wr_resppkt_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    WAIT_B = 2'd2
  } arb_state_e;

  localparam int HAWK_WR_TIMEOUT = 1024;

  // Bits needed to encode value distinct codes; never less than 1 so ports stay legal.
  function automatic int clogb2(input int value);
    int res;
    res = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) begin
        res = i + 1;
      end else begin
        res = res;
      end
    end
    if (res < 1) begin
      res = 1;
    end else begin
      res = res;
    end
    return res;
  endfunction

endpackage

// File: rtl/hawk_rr_pick.sv
// Combinational rotating-priority picker: first set request at or above rr_ptr, wrapping.
module hawk_rr_pick
  import hacd_pkg::*;
#(
  parameter  int NUM_REQ = 3,
  localparam int IDX_W   = clogb2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [IDX_W-1:0]   winner,
  output logic               any
);

  int               sum_s;
  logic [IDX_W-1:0] cand_s;

  // Walk offsets from farthest to nearest so the nearest requester wins.
  always_comb begin
    winner = '0;
    sum_s  = 0;
    cand_s = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      sum_s  = int'(rr_ptr) + i;
      cand_s = (sum_s >= NUM_REQ) ? IDX_W'(sum_s - NUM_REQ) : IDX_W'(sum_s);
      winner = req[cand_s] ? cand_s : winner;
    end
  end

  assign any = |req;

endmodule

// File: rtl/hawk_axiwr_arb.sv
// Round-robin write arbiter for hawk_axiwr_master: one transaction outstanding,
// AW/W issue, B wait with a response watchdog.
module hawk_axiwr_arb
  import hacd_pkg::*;
#(
  parameter  int NUM_REQ     = 3,
  parameter  int TIMEOUT_CYC = HAWK_WR_TIMEOUT,
  localparam int CNT_W       = clogb2(TIMEOUT_CYC + 1),
  localparam int IDX_W       = clogb2(NUM_REQ)
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  input  axi_wr_pld_t [NUM_REQ-1:0] req_pld_i,
  output logic [NUM_REQ-1:0]        req_ack_o,
  output logic [NUM_REQ-1:0]        req_done_o,
  output logic                      req_bresp_o,
  output axi_wr_reqpkt_t            wr_reqpkt_o,
  input  axi_wr_rdypkt_t            wr_rdypkt_i,
  input  axi_wr_resppkt_t           wr_resppkt_i,
  output logic                      busy_o,
  output logic [IDX_W-1:0]          grant_idx_o,
  output logic                      timeout_o
);

  arb_state_e         state_r, state_nxt_s;
  logic [IDX_W-1:0]   rr_ptr_r, rr_ptr_nxt_s;
  logic [IDX_W-1:0]   grant_r, grant_nxt_s;
  axi_wr_pld_t        pld_r, pld_nxt_s;
  logic               aw_pend_r, aw_nxt_s;
  logic               w_pend_r, w_nxt_s;
  logic [CNT_W-1:0]   cnt_r, cnt_nxt_s;
  logic [NUM_REQ-1:0] ack_r, ack_nxt_s;
  logic [NUM_REQ-1:0] done_r, done_nxt_s;
  logic               bresp_r, bresp_nxt_s;
  logic               busy_r;
  logic               timeout_r, timeout_nxt_s;
  logic [IDX_W-1:0]   pick_idx_s;
  logic               pick_any_s;
  logic               expire_s;

  hawk_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req    (req_valid_i),
    .rr_ptr (rr_ptr_r),
    .winner (pick_idx_s),
    .any    (pick_any_s)
  );

  assign expire_s = (TIMEOUT_CYC != 0) && (cnt_r == CNT_W'(TIMEOUT_CYC - 1));

  // Next-state and next-output computation for the arbiter FSM.
  always_comb begin
    state_nxt_s   = state_r;
    rr_ptr_nxt_s  = rr_ptr_r;
    grant_nxt_s   = grant_r;
    pld_nxt_s     = pld_r;
    aw_nxt_s      = aw_pend_r;
    w_nxt_s       = w_pend_r;
    cnt_nxt_s     = cnt_r;
    ack_nxt_s     = '0;
    done_nxt_s    = '0;
    bresp_nxt_s   = 1'b0;
    timeout_nxt_s = timeout_r;
    case (state_r)
      IDLE: begin
        // A B beat arriving here belongs to a timed-out transaction and is dropped.
        if (pick_any_s) begin
          pld_nxt_s              = req_pld_i[pick_idx_s];
          grant_nxt_s            = pick_idx_s;
          rr_ptr_nxt_s           = (pick_idx_s == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx_s + IDX_W'(1);
          ack_nxt_s[pick_idx_s]  = 1'b1;
          aw_nxt_s               = 1'b1;
          w_nxt_s                = 1'b1;
          cnt_nxt_s              = '0;
          state_nxt_s            = ISSUE;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ISSUE: begin
        cnt_nxt_s = cnt_r + CNT_W'(1);
        aw_nxt_s  = aw_pend_r & ~wr_rdypkt_i.awready;
        w_nxt_s   = w_pend_r & ~wr_rdypkt_i.wready;
        if (expire_s) begin
          aw_nxt_s            = 1'b0;
          w_nxt_s             = 1'b0;
          done_nxt_s[grant_r] = 1'b1;
          bresp_nxt_s         = 1'b1;
          timeout_nxt_s       = 1'b1;
          state_nxt_s         = IDLE;
        end else if (!aw_nxt_s && !w_nxt_s) begin
          state_nxt_s = WAIT_B;
        end else begin
          state_nxt_s = ISSUE;
        end
      end
      WAIT_B: begin
        cnt_nxt_s = cnt_r + CNT_W'(1);
        if (wr_resppkt_i.bvalid) begin
          done_nxt_s[grant_r] = 1'b1;
          bresp_nxt_s         = wr_resppkt_i.bresp;
          state_nxt_s         = IDLE;
        end else if (expire_s) begin
          done_nxt_s[grant_r] = 1'b1;
          bresp_nxt_s         = 1'b1;
          timeout_nxt_s       = 1'b1;
          state_nxt_s         = IDLE;
        end else begin
          state_nxt_s = WAIT_B;
        end
      end
      default: begin
        aw_nxt_s    = 1'b0;
        w_nxt_s     = 1'b0;
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r   <= IDLE;
      rr_ptr_r  <= '0;
      grant_r   <= '0;
      pld_r     <= '0;
      aw_pend_r <= 1'b0;
      w_pend_r  <= 1'b0;
      cnt_r     <= '0;
      ack_r     <= '0;
      done_r    <= '0;
      bresp_r   <= 1'b0;
      busy_r    <= 1'b0;
      timeout_r <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      rr_ptr_r  <= rr_ptr_nxt_s;
      grant_r   <= grant_nxt_s;
      pld_r     <= pld_nxt_s;
      aw_pend_r <= aw_nxt_s;
      w_pend_r  <= w_nxt_s;
      cnt_r     <= cnt_nxt_s;
      ack_r     <= ack_nxt_s;
      done_r    <= done_nxt_s;
      bresp_r   <= bresp_nxt_s;
      busy_r    <= (state_nxt_s != IDLE);
      timeout_r <= timeout_nxt_s;
    end
  end

  assign wr_reqpkt_o = '{awvalid: aw_pend_r, wvalid: w_pend_r,
                         addr: pld_r.addr, data: pld_r.data, strb: pld_r.strb};
  assign req_ack_o   = ack_r;
  assign req_done_o  = done_r;
  assign req_bresp_o = bresp_r;
  assign busy_o      = busy_r;
  assign grant_idx_o = grant_r;
  assign timeout_o   = timeout_r;

endmodule

// File: tb/tb_hawk_axiwr_arb.sv
// Scoreboard bench for hawk_axiwr_arb: directed transactions push expected acks,
// AW/W beats and completions; a negedge monitor pops and compares them.
module tb_hawk_axiwr_arb;
  import hacd_pkg::*;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [2:0]          req_valid;
  axi_wr_pld_t [2:0]   req_pld;
  logic [2:0]          ack, done;
  logic                bresp;
  axi_wr_reqpkt_t      reqpkt;
  axi_wr_rdypkt_t      rdy;
  axi_wr_resppkt_t     resp;
  logic                busy;
  logic [1:0]          gidx;
  logic                tmo;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  logic [2:0]   ack_q[$];
  logic [63:0]  aw_q[$];
  logic [511:0] w_q[$];
  logic [3:0]   done_q[$];

  hawk_axiwr_arb #(.NUM_REQ(3), .TIMEOUT_CYC(8)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .req_valid_i  (req_valid),
    .req_pld_i    (req_pld),
    .req_ack_o    (ack),
    .req_done_o   (done),
    .req_bresp_o  (bresp),
    .wr_reqpkt_o  (reqpkt),
    .wr_rdypkt_i  (rdy),
    .wr_resppkt_i (resp),
    .busy_o       (busy),
    .grant_idx_o  (gidx),
    .timeout_o    (tmo)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] oh(input int i);
    oh = 3'b001 << i;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every presented ack, AW/W handshake and done is matched against the queues.
  always @(negedge clk) begin
    if (ack != 3'b000) begin
      if (ack_q.size() == 0) check("unexpected_ack", 64'(ack), 64'd0);
      else check("ack_vec", 64'(ack), 64'(ack_q.pop_front()));
    end
    if (reqpkt.awvalid && rdy.awready) begin
      if (aw_q.size() == 0) check("unexpected_aw", 64'd1, 64'd0);
      else begin
        check("aw_addr", reqpkt.addr, aw_q.pop_front());
        check("aw_strb", reqpkt.strb, 64'hFFFF_FFFF_FFFF_FFFF);
      end
    end
    if (reqpkt.wvalid && rdy.wready) begin
      if (w_q.size() == 0) check("unexpected_w", 64'd1, 64'd0);
      else begin
        logic [511:0] wexp;
        wexp = w_q.pop_front();
        check("w_data_lo", reqpkt.data[63:0], wexp[63:0]);
        check("w_data_hi", reqpkt.data[511:448], wexp[511:448]);
      end
    end
    if (done != 3'b000) begin
      if (done_q.size() == 0) check("unexpected_done", 64'(done), 64'd0);
      else check("done_bresp", 64'({bresp, done}), 64'(done_q.pop_front()));
    end
  end

  // One full transaction starting from an IDLE cycle where req_valid already selects idx.
  task automatic do_txn(input int idx, input int aw_lat, input int w_lat, input int b_lat,
                        input logic b_err, input logic [2:0] valid_after,
                        input logic exp_to, input logic stray_b, input string tag);
    int nlat;
    ack_q.push_back(oh(idx));
    aw_q.push_back(req_pld[idx].addr);
    w_q.push_back(req_pld[idx].data);
    done_q.push_back({b_err, oh(idx)});
    rdy  = '0;
    resp = '0;
    tick();
    check({tag, "_grant"}, 64'(gidx), 64'(idx));
    check({tag, "_issue_valids"}, 64'({reqpkt.awvalid, reqpkt.wvalid}), 64'd3);
    check({tag, "_addr"}, reqpkt.addr, req_pld[idx].addr);
    req_valid = valid_after;
    nlat = (aw_lat > w_lat) ? aw_lat : w_lat;
    for (int c = 0; c <= nlat; c++) begin
      rdy.awready = (c >= aw_lat);
      rdy.wready  = (c >= w_lat);
      resp.bvalid = stray_b && (c == 1);
      tick();
      check({tag, "_awvalid"}, 64'(reqpkt.awvalid), 64'(aw_lat > c));
      check({tag, "_wvalid"}, 64'(reqpkt.wvalid), 64'(w_lat > c));
      check({tag, "_no_early_done"}, 64'(done), 64'd0);
    end
    rdy  = '0;
    resp = '0;
    for (int b = 0; b < b_lat; b++) begin
      tick();
      check({tag, "_wait_b_busy"}, 64'({busy, done}), 64'h8);
    end
    resp.bvalid = 1'b1;
    resp.bresp  = b_err;
    tick();
    resp = '0;
    check({tag, "_done"}, 64'(done), 64'(oh(idx)));
    check({tag, "_bresp"}, 64'(bresp), 64'(b_err));
    check({tag, "_idle"}, 64'(busy), 64'd0);
    check({tag, "_timeout"}, 64'(tmo), 64'(exp_to));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    rst_n     = 1'b0;
    req_valid = 3'b000;
    rdy       = '0;
    resp      = '0;
    req_pld[0] = '{addr: 64'h0000_0000_1000_0000, data: {16{32'hA500_0000}}, strb: '1};
    req_pld[1] = '{addr: 64'h0000_00FF_F610_0040, data: {16{32'hA500_0001}}, strb: '1};
    req_pld[2] = '{addr: 64'h0000_0000_2000_0080, data: {16{32'hA500_0002}}, strb: '1};
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_gidx", 64'(gidx), 64'd0);
    check("rst_outs", 64'({tmo, bresp, ack, done, reqpkt.awvalid, reqpkt.wvalid}), 64'd0);
    repeat (3) tick();
    check("no_req_idle", 64'({busy, ack, done}), 64'd0);

    // Single request from requester 1, then ptr=2 picks 2 out of {0,2}.
    req_valid = 3'b010;
    do_txn(1, 0, 0, 1, 1'b0, 3'b000, 1'b0, 1'b0, "single");
    req_valid = 3'b101;
    do_txn(2, 0, 0, 0, 1'b0, 3'b000, 1'b0, 1'b0, "ptr2");

    // Continuous requests rotate 0,1,2,0.
    req_valid = 3'b111;
    do_txn(0, 0, 0, 0, 1'b0, 3'b111, 1'b0, 1'b0, "rr0");
    do_txn(1, 0, 0, 0, 1'b0, 3'b111, 1'b0, 1'b0, "rr1");
    do_txn(2, 0, 0, 0, 1'b0, 3'b111, 1'b0, 1'b0, "rr2");
    do_txn(0, 0, 0, 0, 1'b0, 3'b000, 1'b0, 1'b0, "rr3");

    // Split AW/W handshake with a stray B during ISSUE.
    req_valid = 3'b010;
    do_txn(1, 1, 4, 1, 1'b0, 3'b000, 1'b0, 1'b1, "split");

    // Error response does not touch the watchdog flag.
    req_valid = 3'b100;
    do_txn(2, 0, 1, 0, 1'b1, 3'b000, 1'b0, 1'b0, "slverr");

    // Watchdog: never ready, never B.
    req_valid = 3'b001;
    ack_q.push_back(oh(0));
    done_q.push_back({1'b1, oh(0)});
    rdy  = '0;
    resp = '0;
    tick();
    check("to_grant", 64'(gidx), 64'd0);
    req_valid = 3'b000;
    for (int k = 1; k <= 7; k++) begin
      tick();
      check("to_pending", 64'({done, reqpkt.awvalid, tmo}), 64'h2);
    end
    tick();
    check("to_done", 64'(done), 64'(oh(0)));
    check("to_bresp", 64'(bresp), 64'd1);
    check("to_flag", 64'(tmo), 64'd1);
    check("to_valids_drop", 64'({reqpkt.awvalid, reqpkt.wvalid, busy}), 64'd0);
    resp.bvalid = 1'b1;
    tick();
    resp = '0;
    check("late_b_ignored", 64'({busy, done}), 64'd0);
    tick();
    check("to_sticky", 64'(tmo), 64'd1);

    // Reset in WAIT_B, then ptr must be back at 0.
    req_valid = 3'b010;
    ack_q.push_back(oh(1));
    aw_q.push_back(req_pld[1].addr);
    w_q.push_back(req_pld[1].data);
    rdy = '{awready: 1'b1, wready: 1'b1};
    tick();
    req_valid = 3'b000;
    tick();
    rdy = '0;
    check("rst_mid_waitb", 64'({busy, reqpkt.awvalid, reqpkt.wvalid}), 64'h4);
    tick();
    rst_n = 1'b0;
    resp.bvalid = 1'b1;
    #1;
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_outs", 64'({tmo, bresp, ack, done, reqpkt.awvalid, reqpkt.wvalid, gidx}), 64'd0);
    check("arst_addr", reqpkt.addr, 64'd0);
    tick();
    rst_n = 1'b1;
    resp  = '0;
    req_valid = 3'b110;
    do_txn(1, 0, 0, 0, 1'b0, 3'b000, 1'b0, 1'b0, "post_rst");

    tick();
    check("ack_q_empty", 64'(ack_q.size()), 64'd0);
    check("aw_q_empty", 64'(aw_q.size()), 64'd0);
    check("w_q_empty", 64'(w_q.size()), 64'd0);
    check("done_q_empty", 64'(done_q.size()), 64'd0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/hawk_axiwr_arb.md
Name: hawk_axiwr_arb

Overview:
- Round-robin arbiter and sequencer that lets several write requesters share the single hawk_axiwr_master port. Requesters are the page-write manager, the ToL updater and the zspage writer.
- Keeps one write transaction outstanding at a time: latch winner payload, drive AW/W, wait for B, return completion to the winner.
- Adds a response watchdog so that a hung B channel cannot stall the hawk control units.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- TIMEOUT_CYC, 1024, cycles allowed from grant to bvalid; 0 disables the watchdog.
- CNT_W, clogb2(TIMEOUT_CYC+1), watchdog counter width (derived, not overridden).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- req_valid_i  in  NUM_REQ  per-requester write request.
- req_pld_i  in  NUM_REQ x axi_wr_pld_t (640)  per-requester addr[63:0]/data[511:0]/strb[63:0].
- req_ack_o  out  NUM_REQ  one-cycle pulse: payload captured.
- req_done_o  out  NUM_REQ  one-cycle pulse: transaction completed.
- req_bresp_o  out  1  status valid with req_done_o; 0 = OK, 1 = error or timeout.
- wr_reqpkt_o  out  axi_wr_reqpkt_t (642)  to hawk_axiwr_master.
- wr_rdypkt_i  in  axi_wr_rdypkt_t (2)  awready/wready.
- wr_resppkt_i  in  axi_wr_resppkt_t (2)  bresp/bvalid; the master always accepts B.
- busy_o  out  1  high in any state except IDLE.
- grant_idx_o  out  clogb2(NUM_REQ)  index of the current or last winner.
- timeout_o  out  1  sticky watchdog flag, cleared only by reset.

Behaviour:

Reset values:
- All outputs 0, state IDLE, rr_ptr = 0, watchdog counter 0.

Arbitration (IDLE):
- If any req_valid_i is high, the winner is the first set bit searching upward from rr_ptr, wrapping at NUM_REQ-1 back to 0.
- At the clock edge:
  - latch req_pld_i[winner] into the payload register;
  - grant_idx_o <= winner;
  - rr_ptr <= (winner+1) mod NUM_REQ;
  - go to ISSUE.
- req_ack_o[winner] pulses during the first ISSUE cycle.

Requester contract:
- req_valid_i and req_pld_i are held stable until ack.
- Valid still high after the ack cycle counts as a new request.

ISSUE:
- wr_reqpkt_o.addr/data/strb are driven from the payload register.
- awvalid and wvalid both rise on ISSUE entry.
- Each is cleared independently on the edge where it is high and its ready is high. AW and W may complete in either order or in the same cycle.
- Once both are done, go to WAIT_B.
- A bvalid seen in ISSUE is ignored.

WAIT_B:
- On bvalid high, at the edge:
  - req_done_o[grant_idx_o] pulses for one cycle;
  - req_bresp_o = bresp;
  - go to IDLE.
- In that done cycle, IDLE may already arbitrate, so back-to-back grants are 1 idle cycle apart at minimum.

Payload outputs:
- wr_reqpkt_o.addr/data/strb hold their last value outside ISSUE.
- awvalid/wvalid are 0 outside ISSUE.

Latency:
- req_valid to awvalid: 1 cycle.
- bvalid to req_done_o: 1 cycle.

Watchdog (TIMEOUT_CYC > 0):
- The counter clears on grant and increments every cycle in ISSUE or WAIT_B.
- On reaching TIMEOUT_CYC-1 without bvalid:
  - deassert awvalid/wvalid;
  - pulse req_done_o[winner] with req_bresp_o = 1;
  - set timeout_o;
  - go to IDLE.
- If bvalid and expiry occur in the same cycle, bvalid wins: normal completion, timeout_o not set.
- A late B arriving after a timeout is discarded in IDLE.

Other boundary conditions:
- No requests: stays in IDLE; all pulses 0.
- All requesters valid continuously: grants cycle 0,1,2,0,..., so no starvation.
- Asynchronous reset mid-transaction: immediate return to reset values; no done pulse is generated.

Decomposition:
- Package hacd_pkg already holds axi_wr_pld_t, axi_wr_reqpkt_t, axi_wr_rdypkt_t, axi_wr_resppkt_t and clogb2.
- Add to hacd_pkg:
  - arb state encoding (IDLE=2'd0, ISSUE=2'd1, WAIT_B=2'd2);
  - default parameter HAWK_WR_TIMEOUT=1024.
- One sub-module, hawk_rr_pick: combinational rotating-priority picker taking (req vector, rr_ptr) and returning (winner index, any). It is reused later by the read-side arbiter.

Test Plan:
1. Single request: requester 1 valid with addr=64'hFFF6100040 and strb all ones; awready and wready high immediately; bvalid 2 cycles later with bresp=0. Expect: ack[1] one cycle after valid; awvalid/wvalid high for 1 cycle with the matching addr; done[1] with bresp 0; rr_ptr = 2.
2. Round robin: all 3 requesters held valid for 3 transactions. Expect grant order 0,1,2, a subsequent grant to 0, and exactly one ack and one done per transaction.
3. Split handshake: awready high at cycle 1 but wready not high until cycle 4. Expect awvalid to drop after cycle 1, wvalid held high through cycle 4, WAIT_B entered only after cycle 4, and no done before bvalid.
4. Timeout: TIMEOUT_CYC=8, bvalid never asserted. Expect done with bresp=1 at 8 cycles after grant, timeout_o=1 sticky, and a late bvalid then ignored.
5. Error response: bvalid with bresp=1. Expect req_bresp_o=1 on the done pulse and timeout_o unchanged at 0.
6. Reset mid-WAIT_B: drop rst_ni for 1 cycle. Expect all outputs and rr_ptr back to 0, no done pulse, and a new request served normally afterwards.
